// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined RV32M multiplier.
package mul_pkg;

    localparam int unsigned MUL_OPERAND_W = 32;
    localparam int unsigned MUL_TAG_W     = 6;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_t;

    // Stage-0 payload layout at default widths: decoded op, extended operands, tag.
    typedef struct packed {
        mul_op_t                   op;
        logic [MUL_OPERAND_W:0]    a_ext;
        logic [MUL_OPERAND_W:0]    b_ext;
        logic [MUL_TAG_W-1:0]      tag;
    } mul_op_pl_t;

    // Product-stage payload layout at default widths: selected result half and tag.
    typedef struct packed {
        logic [MUL_OPERAND_W-1:0]  result;
        logic [MUL_TAG_W-1:0]      tag;
    } mul_res_pl_t;

    function automatic logic op_a_signed(input mul_op_t op);
        return op != MUL_OP_MULHU;
    endfunction

    function automatic logic op_b_signed(input mul_op_t op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

    function automatic logic op_low_half(input mul_op_t op);
        return op == MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid + payload pipeline register with global stall and flush.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Valid bit: reset/flush win over stall so in-flight ops die at the next edge.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
        end
    end

    // Payload is only meaningful with valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!stall_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipelined_mul_unit.sv
// Fixed-latency, fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Optional performance counters are enabled with `define MUL_PERF_CNT_EN.
module pipelined_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned STAGES        = 3,
    parameter int unsigned TAG_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]     out_tag
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]              perf_ops,
    output logic [31:0]              perf_stall
`endif
);

    localparam int unsigned W        = OPERAND_WIDTH;
    localparam int unsigned XW       = W + 1;
    localparam int unsigned WIDE     = 2 * W;
    localparam int unsigned OP_PL_W  = 2 + 2 * XW + TAG_WIDTH;
    localparam int unsigned RES_PL_W = W + TAG_WIDTH;
    localparam int unsigned NRES     = (STAGES == 1) ? 1 : STAGES - 1;

    logic                 stall_c;
    logic                 accept_c;
    mul_op_t              in_op_c;
    logic [XW-1:0]        in_a_ext_c;
    logic [XW-1:0]        in_b_ext_c;

    logic                 src_vld_c;
    mul_op_t              src_op_c;
    logic [XW-1:0]        src_a_c;
    logic [XW-1:0]        src_b_c;
    logic [TAG_WIDTH-1:0] src_tag_c;

    logic [WIDE-1:0]      a_wide_c;
    logic [WIDE-1:0]      b_wide_c;
    logic [WIDE-1:0]      prod_c;
    logic [W-1:0]         result_c;

    logic                 res_vld_q [NRES];
    logic [RES_PL_W-1:0]  res_pl_q  [NRES];

    assign stall_c  = res_vld_q[NRES-1] && !out_ready;
    assign in_ready = !stall_c;
    assign accept_c = in_valid && in_ready;

    // Decode op and extend operands by one bit according to signedness.
    always_comb begin
        in_op_c    = mul_op_t'(in_op);
        in_a_ext_c = {op_a_signed(in_op_c) & in_a[W-1], in_a};
        in_b_ext_c = {op_b_signed(in_op_c) & in_b[W-1], in_b};
    end

    if (STAGES == 1) begin : g_single
        // Single register: multiply straight from the decoded inputs.
        assign src_vld_c = accept_c;
        assign src_op_c  = in_op_c;
        assign src_a_c   = in_a_ext_c;
        assign src_b_c   = in_b_ext_c;
        assign src_tag_c = in_tag;
    end else begin : g_multi
        logic               op_vld_q;
        logic [OP_PL_W-1:0] op_pl_q;

        pipe_stage_reg #(.WIDTH(OP_PL_W)) u_stage0 (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .stall_i (stall_c),
            .valid_i (accept_c),
            .data_i  ({in_op, in_a_ext_c, in_b_ext_c, in_tag}),
            .valid_o (op_vld_q),
            .data_o  (op_pl_q)
        );

        assign src_vld_c = op_vld_q;
        assign src_op_c  = mul_op_t'(op_pl_q[OP_PL_W-1 -: 2]);
        assign src_a_c   = op_pl_q[TAG_WIDTH+XW +: XW];
        assign src_b_c   = op_pl_q[TAG_WIDTH +: XW];
        assign src_tag_c = op_pl_q[TAG_WIDTH-1:0];
    end

    // Signed product; only the low 2W bits are ever selected, so the
    // (W+1)x(W+1) product is formed modulo 2^(2W).
    always_comb begin
        a_wide_c = {{(WIDE-XW){src_a_c[XW-1]}}, src_a_c};
        b_wide_c = {{(WIDE-XW){src_b_c[XW-1]}}, src_b_c};
        prod_c   = a_wide_c * b_wide_c;
        result_c = op_low_half(src_op_c) ? prod_c[W-1:0] : prod_c[WIDE-1:W];
    end

    // Product-carrying registers; retiming is free to pull them into the multiplier.
    for (genvar k = 0; k < NRES; k++) begin : g_res
        logic                vld_d;
        logic [RES_PL_W-1:0] pl_d;

        if (k == 0) begin : g_first
            assign vld_d = src_vld_c;
            assign pl_d  = {result_c, src_tag_c};
        end else begin : g_next
            assign vld_d = res_vld_q[k-1];
            assign pl_d  = res_pl_q[k-1];
        end

        pipe_stage_reg #(.WIDTH(RES_PL_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .stall_i (stall_c),
            .valid_i (vld_d),
            .data_i  (pl_d),
            .valid_o (res_vld_q[k]),
            .data_o  (res_pl_q[k])
        );
    end

    assign out_valid  = res_vld_q[NRES-1];
    assign out_result = res_pl_q[NRES-1][RES_PL_W-1:TAG_WIDTH];
    assign out_tag    = res_pl_q[NRES-1][TAG_WIDTH-1:0];

`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;

    // Saturating event counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (accept_c && !flush && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (in_valid && !in_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
